// File: rtl/password_rom_ram.sv
// Purpose: password store pairing a sparse constant ROM with a 16-bit word RAM, read at one shared address.
// Latency: 1 cycle for both reads; _Match is combinational from the registered read data.
// Backpressure: none; an access is taken every rising edge and a write is accepted whenever wren=1.
//
// Ports:
//   clk, rst_n     - clock and asynchronous active-low reset (clears outputs and every RAM word)
//   _Address       - shared 16-bit address; the ROM decodes all 16 bits, the RAM only [RAM_AW-1:0]
//   _Data_In, wren - RAM write data and write enable
//   _Data_Out      - registered RAM read data (read-first on a same-address write)
//   _Data          - registered ROM read data
//   _Match         - high when RAM word equals a non-zero ROM word
// Optional feature macro: PASSWORD_MATCH_EN (defined: comparator present; undefined: _Match tied to 0).

module password_rom_ram #(
    parameter int RAM_AW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] _Address,
    input  logic [15:0] _Data_In,
    input  logic        wren,
    output logic [15:0] _Data_Out,
    output logic [15:0] _Data,
    output logic        _Match
);

    localparam int DEPTH = 1 << RAM_AW;

    logic [15:0]       mem [DEPTH];
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       rom_word;

    // Upper address bits are dropped, so the RAM aliases every DEPTH words.
    assign ram_addr = _Address[RAM_AW-1:0];

    always_comb begin
        rom_word = 16'h0000;
        case (_Address)
            16'h1476: rom_word = 16'h2017;
            16'h6435: rom_word = 16'h3141;
            16'h5095: rom_word = 16'h5A5A;
            default:  rom_word = 16'h0000;
        endcase
    end

    // RAM is built from resettable flops because reset must clear every word,
    // not just the read ports. The read samples the array before the write
    // lands, which gives read-first behaviour on a same-address access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
            _Data_Out <= 16'h0000;
            _Data     <= 16'h0000;
        end else begin
            _Data_Out <= mem[ram_addr];
            _Data     <= rom_word;
            if (wren) begin
                mem[ram_addr] <= _Data_In;
            end
        end
    end

`ifdef PASSWORD_MATCH_EN
    // A zero ROM word marks "no password here" and must never match.
    assign _Match = (_Data_Out == _Data) && (_Data != 16'h0000);
`else
    assign _Match = 1'b0;
`endif

endmodule

// File: tb/tb_password_rom_ram.sv
module tb_password_rom_ram;

    localparam int RAM_AW = 8;
    localparam int DEPTH  = 1 << RAM_AW;
`ifdef PASSWORD_MATCH_EN
    localparam bit MEN = 1'b1;
`else
    localparam bit MEN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] din;
    logic        wren;
    logic [15:0] dout;
    logic [15:0] drom;
    logic        match;

    int checks   = 0;
    int failures = 0;

    password_rom_ram #(.RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        ._Address  (addr),
        ._Data_In  (din),
        .wren      (wren),
        ._Data_Out (dout),
        ._Data     (drom),
        ._Match    (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RAM as a sparse map keyed by address modulo depth
    // (absent entries read as zero), ROM as a password table.
    logic [15:0] ref_mem [int];
    logic [15:0] rom_tbl [int];

    function automatic logic [15:0] ref_rom(input logic [15:0] a);
        if (rom_tbl.exists(int'(a))) return rom_tbl[int'(a)];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] ref_ram(input logic [15:0] a);
        int k;
        k = int'(a) % DEPTH;
        if (ref_mem.exists(k)) return ref_mem[k];
        return 16'h0000;
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one access, advance past the edge, and compare against the model.
    task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                          input string tag);
        logic [15:0] e_out, e_rom;
        logic        e_m;
        addr = a; din = d; wren = w;
        e_out = ref_ram(a);
        e_rom = ref_rom(a);
        e_m   = MEN && (e_out == e_rom) && (e_rom != 16'h0000);
        if (w) ref_mem[int'(a) % DEPTH] = d;
        @(posedge clk); #1;
        check16({tag, " data_out"}, dout, e_out);
        check16({tag, " data_rom"}, drom, e_rom);
        check1 ({tag, " match"},    match, e_m);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        w;
        logic [15:0] e_out;
        logic [15:0] e_rom;
        logic        e_m;
    } vec_t;

    vec_t vecs [16];

    initial begin
        rom_tbl[16'h1476] = 16'h2017;
        rom_tbl[16'h6435] = 16'h3141;
        rom_tbl[16'h5095] = 16'h5A5A;

        vecs[0]  = '{16'h1476, 16'h0000, 1'b0, 16'h0000, 16'h2017, 1'b0};
        vecs[1]  = '{16'h1476, 16'h0000, 1'b0, 16'h0000, 16'h2017, 1'b0};
        vecs[2]  = '{16'h6435, 16'h0000, 1'b0, 16'h0000, 16'h3141, 1'b0};
        vecs[3]  = '{16'h6435, 16'h0000, 1'b0, 16'h0000, 16'h3141, 1'b0};
        vecs[4]  = '{16'h5095, 16'h0000, 1'b0, 16'h0000, 16'h5A5A, 1'b0};
        vecs[5]  = '{16'h5095, 16'h0000, 1'b0, 16'h0000, 16'h5A5A, 1'b0};
        vecs[6]  = '{16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[7]  = '{16'hFFFF, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[8]  = '{16'h0005, 16'hAAAA, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[9]  = '{16'h0005, 16'h0000, 1'b0, 16'hAAAA, 16'h0000, 1'b0};
        vecs[10] = '{16'h0003, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0};
        vecs[11] = '{16'h0103, 16'h0000, 1'b0, 16'h1234, 16'h0000, 1'b0};
        vecs[12] = '{16'h1476, 16'h2017, 1'b1, 16'h0000, 16'h2017, 1'b0};
        vecs[13] = '{16'h1476, 16'h0000, 1'b0, 16'h2017, 16'h2017, MEN};
        vecs[14] = '{16'h0076, 16'h0000, 1'b0, 16'h2017, 16'h0000, 1'b0};
        vecs[15] = '{16'h1476, 16'h0000, 1'b0, 16'h2017, 16'h2017, MEN};

        rst_n = 1'b0; addr = 16'h0000; din = 16'h0000; wren = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check16("reset data_out", dout, 16'h0000);
        check16("reset data_rom", drom, 16'h0000);
        check1 ("reset match",    match, 1'b0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: ROM lookup, defaults, read-first write, aliasing, match.
        for (int i = 0; i < 16; i++) begin
            addr = vecs[i].a; din = vecs[i].d; wren = vecs[i].w;
            @(posedge clk); #1;
            check16($sformatf("vec%0d data_out", i), dout, vecs[i].e_out);
            check16($sformatf("vec%0d data_rom", i), drom, vecs[i].e_rom);
            check1 ($sformatf("vec%0d match", i),    match, vecs[i].e_m);
        end

        // Async reset between edges with a write pending: outputs clear at
        // once, the pending write is dropped, and earlier writes are erased.
        addr = 16'h0009; din = 16'hBEEF; wren = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check16("async rst data_out", dout, 16'h0000);
        check16("async rst data_rom", drom, 16'h0000);
        check1 ("async rst match",    match, 1'b0);
        @(posedge clk); #1;
        check16("held rst data_rom", drom, 16'h0000);
        wren = 1'b0;
        #3 rst_n = 1'b1;
        ref_mem.delete();
        access(16'h0009, 16'h0000, 1'b0, "aborted write");
        access(16'h0005, 16'h0000, 1'b0, "cleared 0005");
        access(16'h0003, 16'h0000, 1'b0, "cleared 0003");
        access(16'h1476, 16'h0000, 1'b0, "cleared 1476");

        // Address wrap boundary.
        access(16'hFFFF, 16'h5555, 1'b1, "wrap write ffff");
        access(16'h0000, 16'h0000, 1'b0, "wrap read 0000");
        access(16'h00FF, 16'h0000, 1'b0, "alias read 00ff");

        // Randomized traffic biased toward password addresses and values.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] a, d;
            logic        w;
            case ($urandom_range(0, 5))
                0: a = 16'h1476;
                1: a = 16'h6435;
                2: a = 16'h5095;
                3: a = 16'(($urandom_range(0, 255)) | ($urandom_range(0, 255) << 8));
                4: a = 16'($urandom_range(0, 7));
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: d = 16'h2017;
                1: d = 16'h3141;
                2: d = 16'h5A5A;
                default: d = 16'($urandom);
            endcase
            w = ($urandom_range(0, 2) == 0);
            access(a, d, w, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
